// File: rtl/mips_cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_pkg
// Brief    : Shared types and lane helpers for the CPU data-memory bus master.
// Revision : 1.0 - initial release
// ============================================================================
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RDATA = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] c_size_illegal = 2'b11;

    // Big-endian: byteenable[3] is the byte at offset 0.
    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b1000 >> off;
            SIZE_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] place_wdata(input logic [1:0] size, input logic [1:0] off,
                                                input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SIZE_BYTE: d = {24'h0, wdata[7:0]} << {2'd3 - off, 3'b000};
            SIZE_HALF: d = off[1] ? {16'h0, wdata[15:0]} : {wdata[15:0], 16'h0};
            SIZE_WORD: d = wdata;
            default:   d = 32'h0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_bus_lane_extract.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_lane_extract
// Brief    : Picks the addressed lane(s) out of a bus word and extends them.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_bus_lane_extract
    import mips_cpu_bus_pkg::*;
(
    input  logic [31:0] i_readdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_signed,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_readdata[31:24];
            2'd1:    w_byte = i_readdata[23:16];
            2'd2:    w_byte = i_readdata[15:8];
            default: w_byte = i_readdata[7:0];
        endcase
        w_half = i_offset[1] ? i_readdata[15:0] : i_readdata[31:16];

        case (i_size)
            SIZE_BYTE: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_result = {{16{i_signed & w_half[15]}}, w_half};
            SIZE_WORD: o_result = i_readdata;
            default:   o_result = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_master
// Brief    : CPU load/store initiator on a word-addressed big-endian bus with
//            waitrequest stalls and an optional stall timeout.
// Options  : MIPS_CPU_BUS_MASTER_ALIGN_CHECK_EN - misaligned half/word
//            accesses return resp_err instead of being force-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_bus_master
    import mips_cpu_bus_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest
);

    localparam logic       c_timeout_en = (WAIT_TIMEOUT != 0);
    localparam logic [8:0] c_wait_limit = 9'(WAIT_TIMEOUT);

    state_e      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_signed;
    logic [7:0]  r_wait_cnt;
    logic        r_bus_read;
    logic        r_bus_write;
    logic [31:0] r_address;
    logic [3:0]  r_byteenable;
    logic [31:0] r_writedata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic [1:0]  w_off_eff;
    logic        w_size_bad;
    logic        w_misaligned;
    logic        w_timeout;
    logic [31:0] w_ext;

    // Half/word offsets are forced to their natural alignment; with the
    // alignment check enabled the misaligned cases never reach the bus anyway.
    always_comb begin
        w_size_bad = (req_size == c_size_illegal);
        case (req_size)
            SIZE_HALF: w_off_eff = {req_addr[1], 1'b0};
            SIZE_WORD: w_off_eff = 2'b00;
            default:   w_off_eff = req_addr[1:0];
        endcase
`ifdef MIPS_CPU_BUS_MASTER_ALIGN_CHECK_EN
        w_misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                       ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
        w_misaligned = 1'b0;
`endif
        w_timeout = c_timeout_en && (({1'b0, r_wait_cnt} + 9'd1) == c_wait_limit);
    end

    mips_cpu_bus_lane_extract u_extract (
        .i_readdata (readdata),
        .i_size     (r_size),
        .i_offset   (r_off),
        .i_signed   (r_signed),
        .o_result   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
            r_signed     <= 1'b0;
            r_wait_cnt   <= 8'd0;
            r_bus_read   <= 1'b0;
            r_bus_write  <= 1'b0;
            r_address    <= 32'h0;
            r_byteenable <= 4'h0;
            r_writedata  <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_size   <= req_size;
                        r_off    <= w_off_eff;
                        r_signed <= req_signed;
                        if (w_size_bad || w_misaligned) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state      <= ST_BUS;
                            r_wait_cnt   <= 8'd0;
                            r_bus_read   <= ~req_write;
                            r_bus_write  <= req_write;
                            r_address    <= {req_addr[31:2], 2'b00};
                            r_byteenable <= lane_enable(req_size, w_off_eff);
                            r_writedata  <= req_write ? place_wdata(req_size, w_off_eff, req_wdata)
                                                      : 32'h0;
                        end
                    end
                end
                ST_BUS: begin
                    if (!waitrequest) begin
                        r_bus_read  <= 1'b0;
                        r_bus_write <= 1'b0;
                        if (r_write) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_address    <= 32'h0;
                            r_byteenable <= 4'h0;
                            r_writedata  <= 32'h0;
                        end else begin
                            // byteenable stays put while the registered read data arrives
                            r_state <= ST_RDATA;
                        end
                    end else if (w_timeout) begin
                        r_state      <= ST_RESP;
                        r_bus_read   <= 1'b0;
                        r_bus_write  <= 1'b0;
                        r_address    <= 32'h0;
                        r_byteenable <= 4'h0;
                        r_writedata  <= 32'h0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_RDATA: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_ext;
                    r_address    <= 32'h0;
                    r_byteenable <= 4'h0;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign address    = r_address;
    assign write      = r_bus_write;
    assign read       = r_bus_read;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;

endmodule
`default_nettype wire

// File: doc/mips_cpu_bus_master.md
Name: mips_cpu_bus_master

Overview:
- Initiator side of the CPU data-memory bus: accepts one load/store request at a time from the CPU datapath.
- Drives the word-addressed, big-endian, byte-enabled memory bus and honours waitrequest.
- Returns load data aligned and sign/zero extended.
- Sits between the execute/memory stage and the data RAM.

Parameters:
- WAIT_TIMEOUT, 255: max consecutive cycles waitrequest may stay high before the transfer is aborted with resp_err. 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request present
- req_ready  output  1  block idle, can accept a request
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal
- req_signed  input  1  sign-extend the load result (LB/LH)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle pulse: transfer complete
- resp_rdata  output  32  extended load result; 0 for stores
- resp_err  output  1  valid with resp_valid: illegal size, misaligned access, or timeout
- address  output  32  bus word address, bits [1:0] always 00
- write  output  1  bus write strobe
- read  output  1  bus read strobe
- writedata  output  32  lane-placed store data
- readdata  input  32  bus read data, registered by the responder
- byteenable  output  4  lane enables; bit 3 = byte at offset 0 (big-endian)
- waitrequest  input  1  responder stall

Behaviour:
- Reset values: all bus outputs 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 1. Reset is synchronous and aborts any transfer; the FSM returns to IDLE.
- States: IDLE, BUS, RDATA, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch the request and compute lanes.
  - Illegal size goes directly to RESP with resp_err=1.
  - Otherwise go to BUS.
- Lanes, with off = req_addr[1:0]:
  - byte: byteenable = 4'b1000 >> off. Data byte placed in lane (3-off); lane 3 = writedata[31:24].
  - half: off 0 gives 4'b1100; off 2 gives 4'b0011.
  - word: 4'b1111.
- BUS:
  - Assert read or write with address, byteenable and writedata held stable.
  - The transfer is accepted at the first rising edge where waitrequest=0.
  - Write accepted: drop strobes, go to RESP.
  - Read accepted: drop strobes, go to RDATA.
- RDATA (one cycle): sample readdata and keep byteenable stable, because the responder's registered output appears one cycle after acceptance. Then go to RESP.
  - Extract lane(s): byte = readdata[8*(3-off)+:8]; half = readdata[31:16] at off 0, readdata[15:0] at off 2.
  - Sign-extend if req_signed, else zero-extend.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_rdata and resp_err are valid in this cycle only, and 0 in all other cycles.
  - Return to IDLE; req_ready is high again the next cycle, so back-to-back requests are allowed.
- Latency with waitrequest=0: store 2 cycles from acceptance to resp_valid; load 3 cycles.
- Timeout:
  - An 8-bit counter in BUS counts cycles with waitrequest=1 and clears on entry to BUS.
  - When WAIT_TIMEOUT≠0 and the count reaches WAIT_TIMEOUT, drop strobes, go to RESP with resp_err=1 and resp_rdata=0.
- Requests arriving while req_ready=0 are ignored; the CPU must hold them until accepted.
- Input changes after acceptance have no effect, because the request was latched.

Optional Feature:
- Macro: MIPS_CPU_BUS_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A half request with addr[0]=1 or a word request with addr[1:0]≠0 performs no bus cycle.
  - Goes IDLE→RESP with resp_err=1 (MIPS AdEL/AdES source).
- Undefined:
  - Offending low address bits are forced to aligned: half uses addr[1], word uses offset 0.
  - Transfer proceeds and resp_err reflects only illegal size or timeout.

Decomposition:
- Package mips_cpu_bus_pkg holds:
  - the size enum: SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - the FSM state enum;
  - the lane-enable function.
- One natural sub-module: mips_cpu_bus_lane_extract, combinational readdata→extended result, taking size, offset and signed.

Test Plan:
- Word store 0xDEADBEEF to 0x00000004, waitrequest=0 → address=0x4, byteenable=1111, write pulse 1 cycle, resp_valid 2 cycles after accept, resp_err=0.
- LB signed from 0x00000005, memory word 0x12F45678 → byteenable=0100, resp_rdata=0xFFFFFFF4; LBU at the same address → 0x000000F4.
- LH signed at offset 2, word 0x0000807F, waitrequest high for 3 cycles → read held stable 4 cycles, resp_rdata=0xFFFF807F.
- SB 0xAB to 0xBFC00003 → byteenable=0001, writedata[7:0]=0xAB, address=0xBFC00000.
- waitrequest stuck high with WAIT_TIMEOUT=4 → strobes drop after 4 stalled cycles, resp_err=1, resp_rdata=0.
- Reset asserted during BUS → read/write low next edge, req_ready=1, no resp_valid. With the macro defined, LW at 0x2 → no bus strobe, resp_err=1.
